mem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller, directly downstream of the EXE/MEM pipeline register. It consumes the latched load/store type, effective address (ALU result) and forwarded rt value. It drives a split address/data-handshake data-SRAM bus and generates byte enables and store-data lanes. It aligns and extends load data, including LWL/LWR merge, detects address-alignment exceptions, and holds `mem_stall` until the access completes.

---
 rtl/mem_access_ctrl_if.sv | 13 +
 rtl/mem_access_ctrl.sv | 118 +++++++++++
 tb/tb_mem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: split address/data-handshake data-SRAM bus (master drives dreq/dwr/dbe/daddr/dwdata, slave drives daddr_ok/ddata_ok/drdata)
interface mem_access_ctrl_if;
  logic        dreq;
  logic        dwr;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        daddr_ok;
  logic        ddata_ok;
  logic [31:0] drdata;
  modport master (output dreq, dwr, dbe, daddr, dwdata, input daddr_ok, ddata_ok, drdata);
  modport slave (input dreq, dwr, dbe, daddr, dwdata, output daddr_ok, ddata_ok, drdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-SRAM access controller (load/store decode, lanes, load align/merge, AdEL/AdES, stall; bus via mem_access_ctrl_if.master)
module mem_access_ctrl (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               load_type,
  input  logic [3:0]               store_type,
  input  logic [31:0]              addr,
  input  logic [31:0]              rt_data,
  input  logic                     exc_in,
  input  logic                     flush,
  mem_access_ctrl_if.master        bus,
  output logic                     mem_stall,
  output logic [31:0]              load_result,
  output logic                     load_valid,
  output logic                     adel,
  output logic                     ades,
  output logic [31:0]              bad_vaddr
);
  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;
  state_t      state_q, state_d;
  logic        killed_q, killed_d, wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rt_q, rt_d, load_result_q, load_result_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  a_q, a_d;
  logic [1:0]  a;
  logic        is_ld, is_st, ld_err, st_err, access, issue, kill, done_ok;
  logic [3:0]  st_be, req_be;
  logic [31:0] st_wd, req_wd, rd, aligned;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  always_comb begin
    a = addr[1:0];
    is_ld = |load_type & ~load_type[3];
    is_st = |store_type & (store_type <= 4'd5) & ~is_ld;
    ld_err = is_ld & (((load_type == 4'd3 | load_type == 4'd4) & a[0]) | (load_type == 4'd5 & |a));
    st_err = is_st & ((store_type == 4'd2 & a[0]) | (store_type == 4'd3 & |a));
    access = (is_ld | is_st) & ~exc_in & ~flush & ~ld_err & ~st_err;
    st_be = store_type == 4'd1 ? 4'b0001 << a :
            store_type == 4'd2 ? (a[1] ? 4'b1100 : 4'b0011) :
            store_type == 4'd3 ? 4'b1111 :
            store_type == 4'd4 ? 4'b1111 >> ~a : 4'b1111 << a;
    st_wd = store_type == 4'd1 ? {4{rt_data[7:0]}} :
            store_type == 4'd2 ? {2{rt_data[15:0]}} :
            store_type == 4'd3 ? rt_data :
            store_type == 4'd4 ? rt_data >> {~a, 3'b000} : rt_data << {a, 3'b000};
    req_be = is_st ? st_be : 4'b1111;
    req_wd = is_st ? st_wd : 32'd0;
    issue = state_q == IDLE & access;
    kill = killed_q | flush;
    done_ok = state_q == WAIT_DATA & bus.ddata_ok & ~kill;
    rd = bus.drdata;
    bsel = 8'(rd >> {a_q, 3'b000});
    hsel = a_q[1] ? rd[31:16] : rd[15:0];
    aligned = ltype_q == 3'd1 ? {{24{bsel[7]}}, bsel} :
              ltype_q == 3'd2 ? {24'd0, bsel} :
              ltype_q == 3'd3 ? {{16{hsel[15]}}, hsel} :
              ltype_q == 3'd4 ? {16'd0, hsel} :
              ltype_q == 3'd6 ? (rd << {~a_q, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF << {~a_q, 3'b000})) :
              ltype_q == 3'd7 ? (rd >> {a_q, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF >> {a_q, 3'b000})) : rd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      killed_q <= 1'b0;
      wr_q <= 1'b0;
      be_q <= 4'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rt_q <= 32'd0;
      ltype_q <= 3'd0;
      a_q <= 2'd0;
      load_result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      killed_q <= killed_d;
      wr_q <= wr_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rt_q <= rt_d;
      ltype_q <= ltype_d;
      a_q <= a_d;
      load_result_q <= load_result_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = access ? (bus.daddr_ok ? WAIT_DATA : WAIT_ADDR) : IDLE;
      WAIT_ADDR: state_d = bus.daddr_ok ? WAIT_DATA : WAIT_ADDR;
      WAIT_DATA: state_d = bus.ddata_ok ? (kill ? IDLE : DONE) : WAIT_DATA;
      default:   state_d = IDLE;
    endcase
    killed_d = (state_q == WAIT_ADDR | state_q == WAIT_DATA) & kill & ~(state_q == WAIT_DATA & bus.ddata_ok);
    wr_d = issue ? is_st : wr_q;
    be_d = issue ? req_be : be_q;
    addr_d = issue ? {addr[31:2], 2'b00} : addr_q;
    wdata_d = issue ? req_wd : wdata_q;
    ltype_d = issue ? (is_ld ? load_type[2:0] : 3'd0) : ltype_q;
    a_d = issue ? a : a_q;
    rt_d = issue ? rt_data : rt_q;
    load_result_d = done_ok & |ltype_q ? aligned : load_result_q;
  end
  always_comb begin
    bus.dreq = ~rst & (state_q == IDLE ? access : state_q == WAIT_ADDR);
    bus.dwr = ~rst & (state_q == IDLE ? is_st : wr_q);
    bus.dbe = state_q == IDLE ? req_be : be_q;
    bus.daddr = state_q == IDLE ? {addr[31:2], 2'b00} : addr_q;
    bus.dwdata = state_q == IDLE ? req_wd : wdata_q;
    mem_stall = ~rst & (state_q == IDLE ? access : state_q == DONE ? 1'b0 : (kill ? access : 1'b1));
    load_valid = ~rst & state_q == DONE & |ltype_q;
    adel = ~rst & state_q == IDLE & ~exc_in & ld_err;
    ades = ~rst & state_q == IDLE & ~exc_in & st_err;
    load_result = load_result_q;
    bad_vaddr = addr;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: vector table, hand-written corner sequences and randomized ops against a byte-level reference model
module tb_mem_access_ctrl;
  logic clk, rst, exc_in, flush, mem_stall, load_valid, adel, ades;
  logic [3:0] load_type, store_type;
  logic [31:0] addr, rt_data, load_result, bad_vaddr;
  mem_access_ctrl_if bif();
  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .load_type(load_type), .store_type(store_type), .addr(addr),
    .rt_data(rt_data), .exc_in(exc_in), .flush(flush), .bus(bif), .mem_stall(mem_stall),
    .load_result(load_result), .load_valid(load_valid), .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] lt, st;
    logic [31:0] ad, rt, rd;
    logic exc, req;
    logic [3:0] be;
    logic [31:0] wd, res;
    logic adel, ades;
  } vec_t;
  vec_t tbl[18];
  vec_t v;
  int errors = 0, checks = 0;
  int n_req, n_stall, n_lv, n_cyc, ai, sz;
  logic [31:0] res_end, da, wd, bv, lr_model, r_ad, r_rt, r_rd, m_wd;
  logic [3:0] be, r_lt, r_st, m_be;
  logic wr, e_adel, e_ades, held, r_exc, m_ld, m_st, m_err, m_req;
  int r_adly, r_ddly;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] lt, input int a, input logic [31:0] rt, input logic [31:0] d);
    logic [7:0] db[4];
    logic [7:0] rb[4];
    for (int i = 0; i < 4; i++) begin
      db[i] = d[8*i+:8];
      rb[i] = rt[8*i+:8];
    end
    case (lt)
      4'd1: return {{24{db[a][7]}}, db[a]};
      4'd2: return {24'd0, db[a]};
      4'd3: return {{16{db[a+1][7]}}, db[a+1], db[a]};
      4'd4: return {16'd0, db[a+1], db[a]};
      4'd6: begin
        for (int i = 0; i <= a; i++) rb[3-i] = db[a-i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      4'd7: begin
        for (int i = a; i < 4; i++) rb[i-a] = db[i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      default: return d;
    endcase
  endfunction

  task automatic ref_store(input logic [3:0] st, input int a, input logic [31:0] rt, output logic [3:0] obe, output logic [31:0] owd);
    logic [7:0] rb[4];
    logic [7:0] wb[4];
    for (int i = 0; i < 4; i++) begin
      rb[i] = rt[8*i+:8];
      wb[i] = 8'd0;
    end
    obe = 4'd0;
    case (st)
      4'd1: begin obe[a] = 1'b1; for (int i = 0; i < 4; i++) wb[i] = rb[0]; end
      4'd2: begin obe[a] = 1'b1; obe[a+1] = 1'b1; for (int i = 0; i < 4; i++) wb[i] = rb[i%2]; end
      4'd3: begin obe = 4'hF; for (int i = 0; i < 4; i++) wb[i] = rb[i]; end
      4'd4: for (int j = 0; j <= a; j++) begin obe[j] = 1'b1; wb[j] = rb[3-a+j]; end
      4'd5: for (int j = a; j < 4; j++) begin obe[j] = 1'b1; wb[j] = rb[j-a]; end
      default: ;
    endcase
    owd = {wb[3], wb[2], wb[1], wb[0]};
  endtask

  // Presents one instruction as EXE/MEM would (held while stalled) and plays the bus slave.
  task automatic run_op(input logic [3:0] lt, input logic [3:0] st, input logic [31:0] ad, input logic [31:0] rt,
                        input logic [31:0] rdv, input logic exc, input int adly, input int ddly);
    int ph, w;
    bit fin;
    n_req = 0; n_stall = 0; n_lv = 0; n_cyc = 0; held = 1'b1; ph = 0; w = 0; fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge clk); #1;
      load_type = lt; store_type = st; addr = ad; rt_data = rt; exc_in = exc; flush = 1'b0;
      bif.daddr_ok = 1'b0; bif.ddata_ok = 1'b0; bif.drdata = $urandom;
      #1;
      if (ph == 0 && bif.dreq) begin
        if (n_req == 0) begin
          be = bif.dbe; wr = bif.dwr; da = bif.daddr; wd = bif.dwdata;
        end else if ({bif.dwr, bif.dbe, bif.daddr, bif.dwdata} !== {wr, be, da, wd}) held = 1'b0;
        n_req++;
        if (w == adly) begin bif.daddr_ok = 1'b1; ph = 1; w = 0; end
        else w++;
      end else if (ph == 1) begin
        w++;
        if (w == ddly) begin bif.ddata_ok = 1'b1; bif.drdata = rdv; ph = 2; end
      end
      @(negedge clk);
      if (c == 0) begin e_adel = adel; e_ades = ades; bv = bad_vaddr; end
      if (mem_stall) n_stall++;
      if (load_valid) n_lv++;
      res_end = load_result;
      n_cyc++;
      if (!mem_stall) fin = 1;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    load_type = 4'd0; store_type = 4'd0; flush = 1'b0; exc_in = 1'b0;
    bif.daddr_ok = 1'b0; bif.ddata_ok = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{4'd1, 4'd0, 32'h1003, 32'h0, 32'h80112233, 1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0};
    tbl[1]  = '{4'd2, 4'd0, 32'h1002, 32'h0, 32'h80112233, 1'b0, 1'b1, 4'hF, 32'h0, 32'h00000011, 1'b0, 1'b0};
    tbl[2]  = '{4'd3, 4'd0, 32'h1002, 32'h0, 32'h80112233, 1'b0, 1'b1, 4'hF, 32'h0, 32'hFFFF8011, 1'b0, 1'b0};
    tbl[3]  = '{4'd4, 4'd0, 32'h1000, 32'h0, 32'h8011F233, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0000F233, 1'b0, 1'b0};
    tbl[4]  = '{4'd5, 4'd0, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5]  = '{4'd7, 4'd0, 32'h1001, 32'h11223344, 32'hA1B2C3D4, 1'b0, 1'b1, 4'hF, 32'h0, 32'h11A1B2C3, 1'b0, 1'b0};
    tbl[6]  = '{4'd6, 4'd0, 32'h1002, 32'h11223344, 32'hA1B2C3D4, 1'b0, 1'b1, 4'hF, 32'h0, 32'hB2C3D444, 1'b0, 1'b0};
    tbl[7]  = '{4'd0, 4'd5, 32'h2002, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1, 4'hC, 32'hCCDD0000, 32'h0, 1'b0, 1'b0};
    tbl[8]  = '{4'd0, 4'd1, 32'h2001, 32'h12345678, 32'h0, 1'b0, 1'b1, 4'h2, 32'h78787878, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{4'd0, 4'd2, 32'h2002, 32'h12345678, 32'h0, 1'b0, 1'b1, 4'hC, 32'h56785678, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{4'd0, 4'd4, 32'h2001, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1, 4'h3, 32'h0000AABB, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{4'd0, 4'd3, 32'h2000, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0};
    tbl[12] = '{4'd5, 4'd0, 32'h3002, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[13] = '{4'd0, 4'd2, 32'h3001, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[14] = '{4'd3, 4'd0, 32'h3003, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[15] = '{4'd5, 4'd0, 32'h3002, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[16] = '{4'd8, 4'd0, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[17] = '{4'd0, 4'd6, 32'h2000, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    rst = 1'b1; exc_in = 1'b0; flush = 1'b0; store_type = 4'd0; rt_data = 32'd0;
    load_type = 4'd5; addr = 32'h3000;
    bif.daddr_ok = 1'b0; bif.ddata_ok = 1'b0; bif.drdata = 32'd0;
    lr_model = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dreq", bif.dreq, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_lv", load_valid, 1'b0);
    addr = 32'h3002;
    #1 chk("rst_adel", adel, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; load_type = 4'd0;
    @(negedge clk);
    chk("rst_load_result", load_result, 32'd0);
    chk("rst_idle_dreq", bif.dreq, 1'b0);
    for (int i = 0; i < 18; i++) begin
      v = tbl[i];
      run_op(v.lt, v.st, v.ad, v.rt, v.rd, v.exc, 0, 1);
      if (v.req && v.lt != 4'd0) lr_model = v.res;
      chk($sformatf("t%0d_nreq", i), n_req, v.req ? 1 : 0);
      chk($sformatf("t%0d_stall_cycles", i), n_stall, v.req ? 2 : 0);
      chk($sformatf("t%0d_cycles", i), n_cyc, v.req ? 3 : 1);
      chk($sformatf("t%0d_adel", i), e_adel, v.adel);
      chk($sformatf("t%0d_ades", i), e_ades, v.ades);
      if (v.adel | v.ades) chk($sformatf("t%0d_bad_vaddr", i), bv, v.ad);
      if (v.req) begin
        chk($sformatf("t%0d_dbe", i), be, v.be);
        chk($sformatf("t%0d_daddr", i), da, {v.ad[31:2], 2'b00});
        chk($sformatf("t%0d_dwr", i), wr, v.st != 4'd0);
        if (v.st != 4'd0) chk($sformatf("t%0d_dwdata", i), wd, v.wd);
        chk($sformatf("t%0d_load_valid", i), n_lv, v.lt != 4'd0);
      end
      chk($sformatf("t%0d_load_result", i), res_end, lr_model);
    end
    idle_cycle();
    run_op(4'd6, 4'd0, 32'h4001, 32'h11223344, 32'hA1B2C3D4, 1'b0, 3, 1);
    lr_model = 32'hC3D43344;
    chk("lwl_dreq_cycles", n_req, 4);
    chk("lwl_held", held, 1'b1);
    chk("lwl_stall_cycles", n_stall, 5);
    chk("lwl_load_valid", n_lv, 1);
    chk("lwl_result", res_end, 32'hC3D43344);
    idle_cycle();
    @(posedge clk); #1; load_type = 4'd3; addr = 32'h5002; bif.daddr_ok = 1'b1;
    @(negedge clk); chk("fl_issue_dreq", bif.dreq, 1'b1);
    @(posedge clk); #1; bif.daddr_ok = 1'b0; flush = 1'b1;
    @(negedge clk); chk("fl_kill_stall", mem_stall, 1'b0);
    @(posedge clk); #1; flush = 1'b0; load_type = 4'd0; store_type = 4'd3; addr = 32'h6000; rt_data = 32'h01020304;
    @(negedge clk); chk("fl_drain_dreq", bif.dreq, 1'b0); chk("fl_drain_stall", mem_stall, 1'b1);
    @(posedge clk); #1; bif.ddata_ok = 1'b1; bif.drdata = 32'hFFFF0000;
    @(negedge clk); chk("fl_done_dreq", bif.dreq, 1'b0); chk("fl_done_stall", mem_stall, 1'b1); chk("fl_done_lv", load_valid, 1'b0);
    @(posedge clk); #1; bif.ddata_ok = 1'b0; bif.daddr_ok = 1'b1;
    @(negedge clk);
    chk("fl_sw_dreq", bif.dreq, 1'b1); chk("fl_sw_dwr", bif.dwr, 1'b1);
    chk("fl_sw_daddr", bif.daddr, 32'h6000); chk("fl_sw_lv", load_valid, 1'b0); chk("fl_sw_stall", mem_stall, 1'b1);
    @(posedge clk); #1; bif.daddr_ok = 1'b0; bif.ddata_ok = 1'b1;
    @(negedge clk); chk("fl_sw_wait_stall", mem_stall, 1'b1);
    @(posedge clk); #1; bif.ddata_ok = 1'b0;
    @(negedge clk);
    chk("fl_sw_done_stall", mem_stall, 1'b0); chk("fl_sw_done_lv", load_valid, 1'b0);
    chk("fl_load_result_held", load_result, lr_model);
    idle_cycle();
    @(posedge clk); #1; load_type = 4'd5; addr = 32'h7000;
    @(negedge clk); chk("fa_issue_dreq", bif.dreq, 1'b1);
    @(posedge clk); #1; flush = 1'b1; load_type = 4'd0; addr = 32'h77770003;
    @(negedge clk);
    chk("fa_dreq_held", bif.dreq, 1'b1); chk("fa_daddr_latched", bif.daddr, 32'h7000); chk("fa_stall", mem_stall, 1'b0);
    @(posedge clk); #1; flush = 1'b0; bif.daddr_ok = 1'b1;
    @(negedge clk); chk("fa_accept_dreq", bif.dreq, 1'b1);
    @(posedge clk); #1; bif.daddr_ok = 1'b0; bif.ddata_ok = 1'b1; bif.drdata = 32'h12345678;
    @(negedge clk); chk("fa_data_stall", mem_stall, 1'b0); chk("fa_data_lv", load_valid, 1'b0);
    @(posedge clk); #1; bif.ddata_ok = 1'b0;
    @(negedge clk);
    chk("fa_after_lv", load_valid, 1'b0); chk("fa_after_dreq", bif.dreq, 1'b0);
    chk("fa_load_result_held", load_result, lr_model);
    @(posedge clk); #1; load_type = 4'd5; addr = 32'h8000;
    @(negedge clk); chk("rm_dreq", bif.dreq, 1'b1); chk("rm_stall", mem_stall, 1'b1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); chk("rm_rst_dreq", bif.dreq, 1'b0); chk("rm_rst_stall", mem_stall, 1'b0);
    @(posedge clk); #1; rst = 1'b0; load_type = 4'd0;
    @(negedge clk);
    chk("rm_idle_dreq", bif.dreq, 1'b0); chk("rm_idle_stall", mem_stall, 1'b0);
    chk("rm_load_result", load_result, 32'd0);
    lr_model = 32'd0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) begin r_lt = 4'($urandom_range(0, 9)); r_st = 4'd0; end
      else begin r_lt = 4'd0; r_st = 4'($urandom_range(0, 7)); end
      r_ad = $urandom; r_rt = $urandom; r_rd = $urandom;
      r_exc = ($urandom_range(0, 7) == 0);
      r_adly = $urandom_range(0, 3); r_ddly = $urandom_range(1, 3);
      ai = int'(r_ad[1:0]);
      m_ld = r_lt >= 4'd1 && r_lt <= 4'd7;
      m_st = r_st >= 4'd1 && r_st <= 4'd5;
      sz = (r_lt == 4'd3 || r_lt == 4'd4 || r_st == 4'd2) ? 2 : (r_lt == 4'd5 || r_st == 4'd3) ? 4 : 1;
      m_err = (m_ld || m_st) && (ai % sz != 0);
      m_req = (m_ld || m_st) && !r_exc && !m_err;
      run_op(r_lt, r_st, r_ad, r_rt, r_rd, r_exc, r_adly, r_ddly);
      if (m_req && m_ld) lr_model = ref_load(r_lt, ai, r_rt, r_rd);
      chk($sformatf("r%0d_nreq", k), n_req, m_req ? r_adly + 1 : 0);
      chk($sformatf("r%0d_stall_cycles", k), n_stall, m_req ? r_adly + 1 + r_ddly : 0);
      chk($sformatf("r%0d_load_valid", k), n_lv, (m_req && m_ld) ? 1 : 0);
      chk($sformatf("r%0d_adel", k), e_adel, m_ld && m_err && !r_exc);
      chk($sformatf("r%0d_ades", k), e_ades, m_st && m_err && !r_exc);
      chk($sformatf("r%0d_load_result", k), res_end, lr_model);
      if (m_req) begin
        chk($sformatf("r%0d_daddr", k), da, {r_ad[31:2], 2'b00});
        chk($sformatf("r%0d_dwr", k), wr, m_st);
        chk($sformatf("r%0d_held", k), held, 1'b1);
        if (m_st) begin
          ref_store(r_st, ai, r_rt, m_be, m_wd);
          chk($sformatf("r%0d_dbe", k), be, m_be);
          chk($sformatf("r%0d_dwdata", k), wd, m_wd);
        end else chk($sformatf("r%0d_dbe", k), be, 4'hF);
      end
    end
    idle_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
